// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch-stage controller.
// Holds the fetch FSM state encoding, the buffered decode-entry bundle,
// the default reset PC and a PC alignment helper.
package fetch_ctrl_pkg;

  localparam int          FETCH_INST_W     = 32;
  localparam logic [63:0] PC_RESET_DEFAULT = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLD    = 2'd2,
    DISCARD = 2'd3
  } fetch_state_t;

  // Everything decode sees on out_*, kept together so it is loaded atomically.
  typedef struct packed {
    logic                    valid;
    logic [63:0]             pc;
    logic [FETCH_INST_W-1:0] inst;
    logic                    exc_misalign;
  } fetch_data_t;

  // Instructions are word aligned; any low PC bit set is a fetch fault.
  function automatic logic pc_misaligned(input logic [63:0] p);
    return p[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the fetch PC, runs the instruction-bus
// request/response handshake and buffers one entry for decode.
// Ports: clk/resetn; pc_next/flush/flush_pc from selector/execute;
//   pc/iwait back to the selector; ireq_*/iresp_* instruction bus;
//   dec_ready/out_* decode handshake.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [63:0] PC_RESET = PC_RESET_DEFAULT,
  parameter int          INST_W   = FETCH_INST_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [63:0]       pc_next,
  input  logic              flush,
  input  logic [63:0]       flush_pc,
  output logic [63:0]       pc,
  output logic              iwait,
  output logic              ireq_valid,
  output logic [63:0]       ireq_addr,
  input  logic              iresp_data_ok,
  input  logic [INST_W-1:0] iresp_data,
  input  logic              dec_ready,
  output logic              out_valid,
  output logic [63:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_exc_misalign
);

  fetch_state_t r_state;
  logic [63:0]  r_pc;
  logic [63:0]  r_req_addr;
  fetch_data_t  r_out;

  fetch_state_t w_state_nxt;
  logic [63:0]  w_pc_nxt;
  logic [63:0]  w_req_addr_nxt;
  fetch_data_t  w_out_nxt;
  logic         w_ireq_valid;
  logic [63:0]  w_ireq_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_pc       <= PC_RESET;
      r_req_addr <= '0;
      r_out      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_req_addr <= w_req_addr_nxt;
      r_out      <= w_out_nxt;
    end
  end

  // Flush is evaluated first in every state so a redirect always wins over
  // a response or a decode accept landing in the same cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_req_addr_nxt = r_req_addr;
    w_out_nxt      = r_out;
    w_ireq_valid   = 1'b0;
    w_ireq_addr    = r_req_addr;

    case (r_state)
      IDLE: begin
        if (flush) begin
          w_pc_nxt = flush_pc;
        end
        w_state_nxt = REQ;
      end

      REQ: begin
        if (pc_misaligned(r_pc)) begin
          // Fault is raised before any request goes out, so dropping
          // ireq_valid here never abandons a bus transaction.
          if (flush) begin
            w_pc_nxt = flush_pc;
          end else begin
            w_out_nxt.valid        = 1'b1;
            w_out_nxt.pc           = r_pc;
            w_out_nxt.inst         = '0;
            w_out_nxt.exc_misalign = 1'b1;
            w_state_nxt            = HOLD;
          end
        end else begin
          w_ireq_valid   = 1'b1;
          w_ireq_addr    = r_pc;
          w_req_addr_nxt = r_pc;
          if (flush) begin
            w_pc_nxt = flush_pc;
            // A response in the flush cycle closes the request: nothing to drain.
            w_state_nxt = iresp_data_ok ? IDLE : DISCARD;
          end else if (iresp_data_ok) begin
            w_out_nxt.valid        = 1'b1;
            w_out_nxt.pc           = r_pc;
            w_out_nxt.inst         = FETCH_INST_W'(iresp_data);
            w_out_nxt.exc_misalign = 1'b0;
            w_state_nxt            = HOLD;
          end
        end
      end

      HOLD: begin
        if (flush) begin
          w_out_nxt.valid = 1'b0;
          w_pc_nxt        = flush_pc;
          w_state_nxt     = REQ;
        end else if (dec_ready) begin
          w_out_nxt.valid = 1'b0;
          w_pc_nxt        = pc_next;
          w_state_nxt     = REQ;
        end
      end

      DISCARD: begin
        // Keep presenting the squashed address until the bus completes it;
        // the redirect target waits in r_pc.
        w_ireq_valid = 1'b1;
        w_ireq_addr  = r_req_addr;
        if (flush) begin
          w_pc_nxt = flush_pc;
        end
        if (iresp_data_ok) begin
          w_state_nxt = REQ;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign pc               = r_pc;
  assign iwait            = (r_state == REQ) || (r_state == DISCARD);
  assign ireq_valid       = w_ireq_valid;
  assign ireq_addr        = w_ireq_addr;
  assign out_valid        = r_out.valid;
  assign out_pc           = r_out.pc;
  assign out_inst         = INST_W'(r_out.inst);
  assign out_exc_misalign = r_out.exc_misalign;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  localparam logic [63:0] PC_RST = 64'h8000_0000;

  logic        clk;
  logic        resetn;
  logic [63:0] pc_next;
  logic        flush;
  logic [63:0] flush_pc;
  logic [63:0] pc;
  logic        iwait;
  logic        ireq_valid;
  logic [63:0] ireq_addr;
  logic        iresp_data_ok;
  logic [31:0] iresp_data;
  logic        dec_ready;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_exc_misalign;

  int n_vec = 0;
  int n_err = 0;

  fetch_ctrl #(.PC_RESET(PC_RST), .INST_W(32)) dut (
    .clk(clk), .resetn(resetn), .pc_next(pc_next), .flush(flush),
    .flush_pc(flush_pc), .pc(pc), .iwait(iwait), .ireq_valid(ireq_valid),
    .ireq_addr(ireq_addr), .iresp_data_ok(iresp_data_ok),
    .iresp_data(iresp_data), .dec_ready(dec_ready), .out_valid(out_valid),
    .out_pc(out_pc), .out_inst(out_inst), .out_exc_misalign(out_exc_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents as a pure function of address.
  function automatic logic [31:0] mem(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0001;
  endfunction

  function automatic logic [63:0] rand_pc();
    logic [63:0] p;
    p = {$urandom, $urandom};
    if ($urandom_range(7) != 0) p[1:0] = 2'b00;
    return p;
  endfunction

  // Inputs change 1ns after the rising edge; outputs are observed 1ns later.
  task automatic drive(input logic fl, input logic [63:0] fpc, input logic [63:0] pn,
                       input logic dr, input logic dok);
    flush         = fl;
    flush_pc      = fpc;
    pc_next       = pn;
    dec_ready     = dr;
    iresp_data_ok = dok;
    iresp_data    = mem(ireq_addr);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    #20;
    n_vec++; if (pc !== PC_RST) begin n_err++; $display("FAIL rst_pc got=%h exp=%h", pc, PC_RST); end
    n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL rst_ireq_valid got=%b exp=0", ireq_valid); end
    n_vec++; if (iwait !== 1'b0) begin n_err++; $display("FAIL rst_iwait got=%b exp=0", iwait); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL rst_out_pc got=%h exp=0", out_pc); end
    n_vec++; if (ireq_addr !== 64'h0) begin n_err++; $display("FAIL rst_ireq_addr got=%h exp=0", ireq_addr); end
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL idle_ireq_valid got=%b exp=0", ireq_valid); end
    tick();
  endtask

  task automatic test_first_fetch();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b1) begin n_err++; $display("FAIL t1_req_valid got=%b exp=1", ireq_valid); end
    n_vec++; if (ireq_addr !== PC_RST) begin n_err++; $display("FAIL t1_req_addr got=%h exp=%h", ireq_addr, PC_RST); end
    n_vec++; if (iwait !== 1'b1) begin n_err++; $display("FAIL t1_iwait got=%b exp=1", iwait); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t1_early_valid got=%b exp=0", out_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL t1_out_valid got=%b exp=1", out_valid); end
    n_vec++; if (out_pc !== PC_RST) begin n_err++; $display("FAIL t1_out_pc got=%h exp=%h", out_pc, PC_RST); end
    n_vec++; if (out_inst !== mem(PC_RST)) begin n_err++; $display("FAIL t1_out_inst got=%h exp=%h", out_inst, mem(PC_RST)); end
    n_vec++; if (out_exc_misalign !== 1'b0) begin n_err++; $display("FAIL t1_exc got=%b exp=0", out_exc_misalign); end
    n_vec++; if (iwait !== 1'b0) begin n_err++; $display("FAIL t1_hold_iwait got=%b exp=0", iwait); end
    tick();
  endtask

  task automatic test_hold_stall();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, '0, 64'h8000_0004, 1'b0, 1'b0);
      n_vec++; if (out_valid !== 1'b1 || out_pc !== PC_RST || out_inst !== mem(PC_RST))
        begin n_err++; $display("FAIL t2_hold_stable got=%b/%h/%h exp=1/%h/%h", out_valid, out_pc, out_inst, PC_RST, mem(PC_RST)); end
      n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL t2_no_req got=%b exp=0", ireq_valid); end
      tick();
    end
    drive(1'b0, '0, 64'h8000_0004, 1'b1, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004)
      begin n_err++; $display("FAIL t2_next_req got=%b/%h exp=1/80000004", ireq_valid, ireq_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t2_valid_clear got=%b exp=0", out_valid); end
    tick();
  endtask

  task automatic test_flush_req();
    drive(1'b1, 64'h8000_0100, '0, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, '0, 1'b0, (i == 2));
      n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0004)
        begin n_err++; $display("FAIL t3_old_addr got=%b/%h exp=1/80000004", ireq_valid, ireq_addr); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t3_no_valid got=%b exp=0", out_valid); end
      n_vec++; if (pc !== 64'h8000_0100) begin n_err++; $display("FAIL t3_pc got=%h exp=80000100", pc); end
      tick();
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0100)
      begin n_err++; $display("FAIL t3_new_addr got=%b/%h exp=1/80000100", ireq_valid, ireq_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t3_dropped got=%b exp=0", out_valid); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 64'h8000_0200, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_pc !== 64'h8000_0100)
      begin n_err++; $display("FAIL t3_deliver got=%b/%h exp=1/80000100", out_valid, out_pc); end
    tick();
  endtask

  task automatic test_flush_same();
    drive(1'b1, 64'h8000_0300, '0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL t4_no_valid got=%b exp=0", out_valid); end
    n_vec++; if (ireq_valid !== 1'b0 || iwait !== 1'b0)
      begin n_err++; $display("FAIL t4_idle got=%b/%b exp=0/0", ireq_valid, iwait); end
    n_vec++; if (pc !== 64'h8000_0300) begin n_err++; $display("FAIL t4_pc got=%h exp=80000300", pc); end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b1);
    n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== 64'h8000_0300)
      begin n_err++; $display("FAIL t4_new_addr got=%b/%h exp=1/80000300", ireq_valid, ireq_addr); end
    tick();
    drive(1'b0, '0, 64'h8000_0006, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_misalign();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL t5_no_req got=%b exp=0", ireq_valid); end
    n_vec++; if (pc !== 64'h8000_0006) begin n_err++; $display("FAIL t5_pc got=%h exp=80000006", pc); end
    tick();
    drive(1'b0, '0, 64'h8000_0400, 1'b1, 1'b0);
    n_vec++; if (out_valid !== 1'b1 || out_exc_misalign !== 1'b1)
      begin n_err++; $display("FAIL t5_exc got=%b/%b exp=1/1", out_valid, out_exc_misalign); end
    n_vec++; if (out_pc !== 64'h8000_0006) begin n_err++; $display("FAIL t5_out_pc got=%h exp=80000006", out_pc); end
    n_vec++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL t5_hold_req got=%b exp=0", ireq_valid); end
    tick();
  endtask

  task automatic test_reset_discard();
    drive(1'b1, 64'h8000_0500, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (iwait !== 1'b1 || ireq_addr !== 64'h8000_0400)
      begin n_err++; $display("FAIL t6_discard got=%b/%h exp=1/80000400", iwait, ireq_addr); end
    resetn = 1'b0;
    #1;
    n_vec++; if (ireq_valid !== 1'b0 || iwait !== 1'b0 || ireq_addr !== 64'h0)
      begin n_err++; $display("FAIL t6_async_bus got=%b/%b/%h exp=0/0/0", ireq_valid, iwait, ireq_addr); end
    n_vec++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_inst !== 32'h0 || out_exc_misalign !== 1'b0)
      begin n_err++; $display("FAIL t6_async_out got=%b/%h/%h/%b exp=0/0/0/0", out_valid, out_pc, out_inst, out_exc_misalign); end
    n_vec++; if (pc !== PC_RST) begin n_err++; $display("FAIL t6_pc got=%h exp=%h", pc, PC_RST); end
    @(posedge clk); #1;
    resetn = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    n_vec++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST)
      begin n_err++; $display("FAIL t6_restart got=%b/%h exp=1/%h", ireq_valid, ireq_addr, PC_RST); end
    tick();
  endtask

  // Transaction-level reference: the architectural PC moves only on flush or
  // an accepted entry; any request in flight at a flush is squashed; a
  // delivered entry always belongs to the architectural PC.
  task automatic test_random();
    logic [63:0] m_pc, m_addr, fpc, pn;
    logic        m_outst, m_sq, fl, dr, dok;
    int          exp_v, idle_run;
    resetn = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    resetn   = 1'b1;
    m_pc     = PC_RST;
    m_addr   = '0;
    m_outst  = 1'b0;
    m_sq     = 1'b0;
    exp_v    = 0;
    idle_run = 0;
    for (int c = 0; c < 3000; c++) begin
      fl  = ($urandom_range(9) == 0);
      fpc = rand_pc();
      pn  = rand_pc();
      dr  = $urandom_range(1);
      dok = ireq_valid && ($urandom_range(2) == 0);
      drive(fl, fpc, pn, dr, dok);

      n_vec++; if (pc !== m_pc) begin n_err++; $display("FAIL rnd_pc c=%0d got=%h exp=%h", c, pc, m_pc); end
      if (exp_v >= 0) begin
        n_vec++; if (out_valid !== exp_v[0]) begin n_err++; $display("FAIL rnd_valid c=%0d got=%b exp=%0d", c, out_valid, exp_v); end
      end
      if (out_valid === 1'b1) begin
        n_vec++; if (out_pc !== m_pc || out_exc_misalign !== (m_pc[1:0] != 2'b00) || ireq_valid !== 1'b0)
          begin n_err++; $display("FAIL rnd_entry c=%0d got=%h/%b/%b exp=%h/%b/0", c, out_pc, out_exc_misalign, ireq_valid, m_pc, (m_pc[1:0] != 2'b00)); end
        if (m_pc[1:0] == 2'b00) begin
          n_vec++; if (out_inst !== mem(m_pc)) begin n_err++; $display("FAIL rnd_inst c=%0d got=%h exp=%h", c, out_inst, mem(m_pc)); end
        end
      end
      if (ireq_valid === 1'b1) begin
        if (m_outst) begin
          n_vec++; if (ireq_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr_stable c=%0d got=%h exp=%h", c, ireq_addr, m_addr); end
        end else begin
          n_vec++; if (ireq_addr !== m_pc || m_pc[1:0] != 2'b00)
            begin n_err++; $display("FAIL rnd_new_req c=%0d got=%h exp=%h", c, ireq_addr, m_pc); end
          m_outst = 1'b1;
          m_addr  = m_pc;
          m_sq    = 1'b0;
        end
      end
      if (ireq_valid === 1'b1 || out_valid === 1'b1) idle_run = 0;
      else idle_run++;
      if (idle_run > 8) begin
        n_err++; $display("FAIL rnd_stall c=%0d idle_cycles=%0d limit=8", c, idle_run);
        idle_run = 0;
      end

      exp_v = -1;
      if (ireq_valid === 1'b1 && dok) begin
        exp_v   = (!m_sq && !fl) ? 1 : 0;
        m_outst = 1'b0;
      end else if (m_outst && fl) begin
        m_sq = 1'b1;
      end
      if (out_valid === 1'b1) exp_v = (fl || dr) ? 0 : 1;
      if (fl) m_pc = fpc;
      else if (out_valid === 1'b1 && dr) m_pc = pn;
      tick();
    end
  endtask

  initial begin
    resetn        = 1'b0;
    flush         = 1'b0;
    flush_pc      = '0;
    pc_next       = '0;
    dec_ready     = 1'b0;
    iresp_data_ok = 1'b0;
    iresp_data    = '0;
    #2;
    test_reset();
    test_first_fetch();
    test_hold_stall();
    test_flush_req();
    test_flush_same();
    test_misalign();
    test_reset_discard();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    n_err++;
    $display("FAIL watchdog time=%0t limit=1000000", $time);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "timeout");
  end

endmodule
